// File: rtl/mem8x8_pkg.sv
// Shared definitions for the 8x8 latch-array access controller: state
// encodings, default geometry and the strobe counter load helper.
package mem8x8_pkg;

  typedef logic [1:0] state_t;

  localparam int DEF_ADDR_W     = 3;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_STROBE_CYC = 1;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETUP  = 2'd1;
  localparam state_t ST_STROBE = 2'd2;
  localparam state_t ST_HOLD   = 2'd3;

  // The counter holds the number of strobe cycles still to follow the current one.
  function automatic logic [3:0] strobe_load(input int cyc);
    return 4'(cyc - 1);
  endfunction

endpackage

// File: rtl/mem8x8_row_dec.sv
// ADDR_W-to-ROWS one-hot row decoder with enable; all zeros when disabled.
module mem8x8_row_dec #(
  parameter int ADDR_W = 3
) (
  input  logic                     en,
  input  logic [ADDR_W-1:0]        addr,
  output logic [(1<<ADDR_W)-1:0]   row
);

  always_comb begin
    row = '0;
    if (en) row[addr] = 1'b1;
  end

endmodule

// File: rtl/mem8x8_ctrl.sv
// Access controller for the 8x8 latch array: sequences SETUP/STROBE/HOLD so
// the bitcell enables never overlap or glitch; every output is a flop.
module mem8x8_ctrl
  import mem8x8_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STROBE_CYC = DEF_STROBE_CYC
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req,
  input  logic                     wr,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic                     ready,
  output logic                     rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic [(1<<ADDR_W)-1:0]   we,
  output logic [(1<<ADDR_W)-1:0]   wen,
  output logic [(1<<ADDR_W)-1:0]   re,
  output logic [(1<<ADDR_W)-1:0]   ren,
  output logic [DATA_W-1:0]        bl_in,
  input  logic [DATA_W-1:0]        bl_out
);

  localparam int ROWS = 1 << ADDR_W;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   bl_in_q, bl_in_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                ready_q, ready_d;
  logic [ROWS-1:0]     we_q, we_d;
  logic [ROWS-1:0]     re_q, re_d;
  logic                strobe_en;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    bl_in_d   = bl_in_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    ready_d   = ready_q;
    strobe_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req && ready_q) begin
          state_d = ST_SETUP;
          ready_d = 1'b0;
          wr_d    = wr;
          addr_d  = addr;
          if (wr) bl_in_d = wdata;
        end
      end
      ST_SETUP: begin
        state_d   = ST_STROBE;
        cnt_d     = strobe_load(STROBE_CYC);
        strobe_en = 1'b1;
      end
      ST_STROBE: begin
        if (cnt_q == 4'd0) begin
          // Last strobe edge: the selected row is still driving bl_out.
          state_d = ST_HOLD;
          if (!wr_q) begin
            rdata_d  = bl_out;
            rvalid_d = 1'b1;
          end
        end else begin
          cnt_d     = cnt_q - 4'd1;
          strobe_en = 1'b1;
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  mem8x8_row_dec #(.ADDR_W(ADDR_W)) u_we_dec (
    .en   (strobe_en && wr_q),
    .addr (addr_q),
    .row  (we_d)
  );

  mem8x8_row_dec #(.ADDR_W(ADDR_W)) u_re_dec (
    .en   (strobe_en && !wr_q),
    .addr (addr_q),
    .row  (re_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      bl_in_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ready_q  <= 1'b1;
      we_q     <= '0;
      re_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      bl_in_q  <= bl_in_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ready_q  <= ready_d;
      we_q     <= we_d;
      re_q     <= re_d;
    end
  end

  // Complements are inverted copies of the same flops, so a pair can never skew.
  assign we     = we_q;
  assign wen    = ~we_q;
  assign re     = re_q;
  assign ren    = ~re_q;
  assign ready  = ready_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign bl_in  = bl_in_q;

endmodule

// File: tb/tb_mem8x8_ctrl.sv
// Bench: two controllers (STROBE_CYC 1 and 3), each driving its own
// behavioural 8x8 array so reads return what earlier writes stored.
module tb_mem8x8_ctrl;

  logic       clk = 1'b0;
  logic       rst_n [2];
  logic       req   [2];
  logic       wr    [2];
  logic [2:0] addr  [2];
  logic [7:0] wdata [2];
  logic       ready [2];
  logic       rvalid[2];
  logic [7:0] rdata [2];
  logic [7:0] we    [2];
  logic [7:0] wen   [2];
  logic [7:0] re    [2];
  logic [7:0] ren   [2];
  logic [7:0] bl_in [2];
  logic [7:0] bl_out[2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem8x8_ctrl #(.ADDR_W(3), .DATA_W(8), .STROBE_CYC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n[0]), .req(req[0]), .wr(wr[0]), .addr(addr[0]),
    .wdata(wdata[0]), .ready(ready[0]), .rvalid(rvalid[0]), .rdata(rdata[0]),
    .we(we[0]), .wen(wen[0]), .re(re[0]), .ren(ren[0]), .bl_in(bl_in[0]),
    .bl_out(bl_out[0])
  );

  mem8x8_ctrl #(.ADDR_W(3), .DATA_W(8), .STROBE_CYC(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n[1]), .req(req[1]), .wr(wr[1]), .addr(addr[1]),
    .wdata(wdata[1]), .ready(ready[1]), .rvalid(rvalid[1]), .rdata(rdata[1]),
    .we(we[1]), .wen(wen[1]), .re(re[1]), .ren(ren[1]), .bl_in(bl_in[1]),
    .bl_out(bl_out[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural array: row latches capture bl_in while their we is high.
  for (genvar g = 0; g < 2; g++) begin : g_array
    logic [7:0] mem [8];
    initial for (int r = 0; r < 8; r++) mem[r] = 8'h00;
    always @(negedge clk)
      for (int r = 0; r < 8; r++)
        if (we[g][r]) mem[r] <= bl_in[g];
    always_comb begin
      bl_out[g] = 8'h00;
      for (int r = 0; r < 8; r++)
        if (re[g][r]) bl_out[g] = bl_out[g] | mem[r];
    end
  end

  // Enable-pair invariants on every falling edge, including during reset.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic ok;
      ok = (wen[i] === ~we[i]) && (ren[i] === ~re[i]) &&
           ($countones(we[i] | re[i]) <= 1) && !((|we[i]) && (|re[i]));
      check($sformatf("inv%0d", i), {31'd0, ok}, 32'd1);
    end
  end

  task automatic access(input int i, input logic w, input logic [2:0] a,
                        input logic [7:0] d, input string tag);
    int         sc;
    int         k;
    logic [7:0] oh;
    sc = (i == 0) ? 1 : 3;
    oh = 8'd1 << a;
    @(negedge clk);
    k = 0;
    while (!ready[i] && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, ".idle"}, {31'd0, ready[i]}, 32'd1);
    req[i] = 1'b1; wr[i] = w; addr[i] = a; wdata[i] = d;
    @(posedge clk);
    #1 req[i] = 1'b0;
    @(negedge clk);
    check({tag, ".setup_rdy"}, {31'd0, ready[i]}, 32'd0);
    check({tag, ".setup_strb"}, {16'd0, we[i], re[i]}, 32'd0);
    if (w) check({tag, ".setup_bl"}, {24'd0, bl_in[i]}, {24'd0, d});
    for (int s = 0; s < sc; s++) begin
      @(negedge clk);
      if (w) begin
        check($sformatf("%s.we%0d", tag, s), {16'd0, we[i], wen[i]}, {16'd0, oh, ~oh});
        check($sformatf("%s.bl%0d", tag, s), {24'd0, bl_in[i]}, {24'd0, d});
        check($sformatf("%s.re%0d", tag, s), {24'd0, re[i]}, 32'd0);
      end else begin
        check($sformatf("%s.re%0d", tag, s), {16'd0, re[i], ren[i]}, {16'd0, oh, ~oh});
        check($sformatf("%s.we%0d", tag, s), {24'd0, we[i]}, 32'd0);
      end
      check($sformatf("%s.rv%0d", tag, s), {31'd0, rvalid[i]}, 32'd0);
    end
    @(negedge clk);
    check({tag, ".hold_strb"}, {16'd0, we[i], re[i]}, 32'd0);
    check({tag, ".hold_rdy"}, {31'd0, ready[i]}, 32'd0);
    check({tag, ".hold_rv"}, {31'd0, rvalid[i]}, {31'd0, !w});
    if (w) check({tag, ".hold_bl"}, {24'd0, bl_in[i]}, {24'd0, d});
    else   check({tag, ".rdata"}, {24'd0, rdata[i]}, {24'd0, d});
    @(negedge clk);
    check({tag, ".done_rdy"}, {31'd0, ready[i]}, 32'd1);
    check({tag, ".done_rv"}, {31'd0, rvalid[i]}, 32'd0);
    if (!w) check({tag, ".rdata_hold"}, {24'd0, rdata[i]}, {24'd0, d});
  endtask

  initial begin
    int hits;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b1; req[i] = 1'b0; wr[i] = 1'b0; addr[i] = 3'd0; wdata[i] = 8'h00;
    end

    // Asynchronous reset, asserted between clock edges.
    #2 rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst%0d.ready", i), {31'd0, ready[i]}, 32'd1);
      check($sformatf("rst%0d.rvalid", i), {31'd0, rvalid[i]}, 32'd0);
      check($sformatf("rst%0d.we_re", i), {16'd0, we[i], re[i]}, 32'h0000);
      check($sformatf("rst%0d.wen_ren", i), {16'd0, wen[i], ren[i]}, 32'hFFFF);
      check($sformatf("rst%0d.bl_rd", i), {16'd0, bl_in[i], rdata[i]}, 32'h0000);
    end
    #19 rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    access(0, 1'b1, 3'd3, 8'hA5, "wr3");
    access(0, 1'b0, 3'd3, 8'hA5, "rd3");
    access(0, 1'b0, 3'd5, 8'h00, "rd5");

    access(1, 1'b1, 3'd0, 8'h3C, "lwr0");
    access(1, 1'b0, 3'd0, 8'h3C, "lrd0");

    // Back-to-back writes with req held high, then a busy pulse.
    @(negedge clk);
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 3'd1; wdata[0] = 8'h11;
    @(posedge clk);
    #1 addr[0] = 3'd7; wdata[0] = 8'h77;
    @(negedge clk);
    @(negedge clk);
    check("b2b.we1", {24'd0, we[0]}, 32'h02);
    @(negedge clk);
    check("b2b.hold", {23'd0, ready[0], we[0]}, 32'h000);
    @(negedge clk);
    check("b2b.rdy", {31'd0, ready[0]}, 32'd1);
    @(negedge clk);
    check("b2b.acc2", {31'd0, ready[0]}, 32'd0);
    check("b2b.bl2", {24'd0, bl_in[0]}, 32'h77);
    req[0] = 1'b0;
    @(negedge clk);
    check("b2b.we7", {24'd0, we[0]}, 32'h80);
    req[0] = 1'b1; addr[0] = 3'd5; wdata[0] = 8'hEE;
    @(posedge clk);
    #1 req[0] = 1'b0;
    @(negedge clk);
    check("b2b.hold2", {24'd0, we[0]}, 32'h00);
    @(negedge clk);
    check("b2b.rdy2", {31'd0, ready[0]}, 32'd1);
    @(negedge clk);
    check("b2b.noq", {31'd0, ready[0]}, 32'd1);
    check("b2b.noq_bl", {24'd0, bl_in[0]}, 32'h77);
    access(0, 1'b0, 3'd1, 8'h11, "b2b.rd1");
    access(0, 1'b0, 3'd7, 8'h77, "b2b.rd7");
    access(0, 1'b0, 3'd5, 8'h00, "b2b.rd5");

    // Reset during the strobe of a read.
    @(negedge clk);
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 3'd0;
    @(posedge clk);
    #1 req[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort.re", {24'd0, re[1]}, 32'h01);
    #2 rst_n[1] = 1'b0;
    #1;
    check("abort.re0", {16'd0, re[1], ren[1]}, 32'h00FF);
    check("abort.rdy", {31'd0, ready[1]}, 32'd1);
    @(negedge clk);
    rst_n[1] = 1'b1;
    hits = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rvalid[1]) hits++;
    end
    check("abort.no_rv", hits, 32'd0);
    check("abort.rdata", {24'd0, rdata[1]}, 32'h00);
    access(1, 1'b1, 3'd6, 8'h5A, "post.wr6");
    access(1, 1'b0, 3'd6, 8'h5A, "post.rd6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
